// File: rtl/core_trace_pkg.sv
// Shared types and defaults for the retirement-trace scheduler.
package core_trace_pkg;

  localparam int REC_W_DEF   = 192;
  localparam int ORDER_W_DEF = 64;
  localparam int DROP_W_DEF  = 16;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } trace_state_e;

  typedef struct packed {
    logic                   gap;
    logic [ORDER_W_DEF-1:0] order;
    logic [REC_W_DEF-1:0]   data;
  } trace_entry_t;

endpackage

// File: rtl/core_trace_fifo.sv
// Synchronous FIFO with wrap-bit pointers; pop does not free a slot for a same-cycle push.
module core_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         g_clk,
  input  logic         g_reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;

  // Storage and pointer update; reset flushes contents and pointers.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push && !full) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign rdata = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: rtl/core_trace_ctrl.sv
// Retirement-trace scheduler: OFF/RUN/DRAIN sequencing, order tagging, stall-or-drop on full.
module core_trace_ctrl
  import core_trace_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int REC_W   = REC_W_DEF,
  parameter int ORDER_W = ORDER_W_DEF,
  parameter int DROP_W  = DROP_W_DEF
) (
  input  logic               g_clk,
  input  logic               g_reset,
  input  logic               cfg_en,
  input  logic               cfg_drop,
  input  logic               ret_valid,
  output logic               ret_ready,
  input  logic [REC_W-1:0]   ret_data,
  output logic               trc_valid,
  input  logic               trc_ready,
  output logic [REC_W-1:0]   trc_data,
  output logic [ORDER_W-1:0] trc_order,
  output logic               trc_gap,
  output logic [DROP_W-1:0]  drop_count,
  output logic               busy
);

  typedef struct packed {
    logic               gap;
    logic [ORDER_W-1:0] order;
    logic [REC_W-1:0]   data;
  } entry_t;

  localparam logic [ORDER_W-1:0] ORDER_ONE = 1;
  localparam logic [DROP_W-1:0]  DROP_ONE  = 1;

  trace_state_e       state_r;
  trace_state_e       next_state_s;
  logic [ORDER_W-1:0] order_r;
  logic               gap_pend_r;
  logic [DROP_W-1:0]  drop_cnt_r;
  logic               full_s;
  logic               empty_s;
  logic               ret_hs_s;
  logic               push_s;
  logic               drop_s;
  logic               pop_s;
  logic               arm_s;
  entry_t             wr_entry_s;
  entry_t             rd_entry_s;

  core_trace_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .push    (push_s),
    .wdata   (wr_entry_s),
    .pop     (pop_s),
    .rdata   (rd_entry_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // State register.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_r <= OFF;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; re-enable wins over the drain-complete check.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      OFF:     next_state_s = cfg_en ? RUN : OFF;
      RUN:     next_state_s = cfg_en ? RUN : DRAIN;
      DRAIN: begin
        if (cfg_en) begin
          next_state_s = RUN;
        end else if (empty_s) begin
          next_state_s = OFF;
        end else begin
          next_state_s = DRAIN;
        end
      end
      default: next_state_s = OFF;
    endcase
  end

  // Handshake decode; full is the start-of-cycle flag so trc_ready never reaches ret_ready.
  always_comb begin
    ret_ready = 1'b1;
    case (state_r)
      OFF:     ret_ready = 1'b1;
      RUN:     ret_ready = cfg_drop ? 1'b1 : !full_s;
      DRAIN:   ret_ready = 1'b1;
      default: ret_ready = 1'b1;
    endcase
    ret_hs_s = ret_valid && ret_ready;
    push_s   = (state_r == RUN) && ret_hs_s && !full_s;
    drop_s   = (state_r == RUN) && ret_hs_s && full_s;
    arm_s    = (state_r == OFF) && cfg_en;
    pop_s    = !empty_s && trc_ready;
  end

  // Order counter, pending-gap flag and saturating drop counter.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      order_r    <= '0;
      gap_pend_r <= 1'b0;
      drop_cnt_r <= '0;
    end else begin
      if (push_s || drop_s) begin
        order_r <= order_r + ORDER_ONE;
      end
      if (arm_s) begin
        gap_pend_r <= 1'b0;
      end else if (drop_s) begin
        gap_pend_r <= 1'b1;
      end else if (push_s) begin
        gap_pend_r <= 1'b0;
      end
      if (arm_s) begin
        drop_cnt_r <= '0;
      end else if (drop_s && (drop_cnt_r != {DROP_W{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + DROP_ONE;
      end
    end
  end

  assign wr_entry_s = '{gap: gap_pend_r, order: order_r, data: ret_data};
  assign trc_valid  = !empty_s;
  assign trc_data   = rd_entry_s.data;
  assign trc_order  = rd_entry_s.order;
  assign trc_gap    = rd_entry_s.gap;
  assign drop_count = drop_cnt_r;
  assign busy       = (state_r != OFF) || !empty_s;

endmodule
